// File: rtl/scroll_pkg.sv
// rtl/scroll_pkg.sv - shared constants, state encoding and index helper for the scroll sequencer
package scroll_pkg;

    // All segments are active-low, so an all-ones code lights nothing.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Message index shown on digit k (k = 7 is leftmost) for window position pos.
    function automatic int unsigned win_idx(input int unsigned pos,
                                            input int unsigned k,
                                            input int unsigned len);
        return (pos + 7 - k) % len;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// rtl/step_prescaler.sv - divides clk down to one tick every CLK_DIV enabled cycles
module step_prescaler #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Tick is gated by en so a frozen count never fires.
    assign tick = en && (cnt == LAST);

    // Count only while enabled; hold otherwise so a pause resumes mid-period.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scroll_ctrl.sv
// rtl/scroll_ctrl.sv - 8-digit sliding window sequencer over a writable segment-code message
module scroll_ctrl
    import scroll_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int MSG_LEN = 16,
    parameter int SEG_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       pause,
    input  logic                       dir,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [SEG_W-1:0]           wr_data,
    output logic [SEG_W-1:0]           code7,
    output logic [SEG_W-1:0]           code6,
    output logic [SEG_W-1:0]           code5,
    output logic [SEG_W-1:0]           code4,
    output logic [SEG_W-1:0]           code3,
    output logic [SEG_W-1:0]           code2,
    output logic [SEG_W-1:0]           code1,
    output logic [SEG_W-1:0]           code0,
    output logic                       busy,
    output logic                       step
);

    localparam int AW = $clog2(MSG_LEN);
    localparam logic [SEG_W-1:0] BLANK = (SEG_W == 8) ? SEG_W'(SEG_BLANK) : {SEG_W{1'b1}};

    state_t          state, state_nxt;
    logic [AW-1:0]   pos, pos_nxt;
    logic            load_start;
    logic            tick;
    logic            pre_en, pre_clr;
    logic [SEG_W-1:0] msg [MSG_LEN];
    logic [SEG_W-1:0] win [8];

    // Counting only in RUN; cleared while idle so a fresh start begins a full period.
    assign pre_en  = (state == ST_RUN) && !stop;
    assign pre_clr = (state == ST_IDLE) || stop;

    step_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; stop overrides start, start overrides pause.
    always_comb begin
        state_nxt  = state;
        load_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt  = ST_RUN;
                    load_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (pause) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (stop) begin
            state_nxt  = ST_IDLE;
            load_start = 1'b0;
        end
    end

    // Window position after this edge; dir only matters on a step.
    always_comb begin
        pos_nxt = pos;
        if (load_start) begin
            pos_nxt = '0;
        end else if (tick) begin
            pos_nxt = dir ? pos - 1'b1 : pos + 1'b1;
        end
    end

    // Position register and the eight digit registers, reloaded together.
    always_ff @(posedge clk) begin
        if (rst || stop) begin
            pos <= '0;
            for (int unsigned k = 0; k < 8; k++) begin
                win[3'(k)] <= BLANK;
            end
        end else begin
            pos <= pos_nxt;
            if (load_start || tick) begin
                for (int unsigned k = 0; k < 8; k++) begin
                    win[3'(k)] <= msg[AW'(win_idx(32'(pos_nxt), k, MSG_LEN))];
                end
            end
        end
    end

    // Step pulse lines up with the window change it announces.
    always_ff @(posedge clk) begin
        if (rst) begin
            step <= 1'b0;
        end else begin
            step <= tick;
        end
    end

    // Message store is not reset; a reload on the same edge reads the old contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            msg[wr_addr] <= wr_data;
        end
    end

    assign busy  = (state != ST_IDLE);
    assign code7 = win[7];
    assign code6 = win[6];
    assign code5 = win[5];
    assign code4 = win[4];
    assign code3 = win[3];
    assign code2 = win[2];
    assign code1 = win[1];
    assign code0 = win[0];

endmodule

// File: tb/tb_scroll_ctrl.sv
// tb/tb_scroll_ctrl.sv - directed self-checking bench for scroll_ctrl
module tb_scroll_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, dir, wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] code [8];
    logic       busy, step;
    logic [7:0] model [16];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    scroll_ctrl #(
        .CLK_DIV (4),
        .MSG_LEN (16),
        .SEG_W   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .dir     (dir),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .code7   (code[7]),
        .code6   (code[6]),
        .code5   (code[5]),
        .code4   (code[4]),
        .code3   (code[3]),
        .code2   (code[2]),
        .code1   (code[1]),
        .code0   (code[0]),
        .busy    (busy),
        .step    (step)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_win(input string tag, input int p);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s code%0d", tag, k), code[3'(k)], model[4'((p + 7 - k) % 16)]);
        end
    endtask

    task automatic check_blank(input string tag);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s blank%0d", tag, k), code[3'(k)], 8'hFF);
        end
    endtask

    task automatic do_step(input string tag);
        repeat (3) cyc();
        check({tag, " early"}, 8'(step), 8'h00);
        cyc();
        check({tag, " step"}, 8'(step), 8'h01);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; dir = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) cyc();
        check_blank("reset");
        check("reset busy", 8'(busy), 8'h00);
        check("reset step", 8'(step), 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'(8'h10 + i);
            model[i] = 8'(8'h10 + i);
            cyc();
        end
        wr_en = 1'b0;
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("idle pause busy", 8'(busy), 8'h00);
        check_blank("idle");

        // start: window 10..17 one cycle later
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_win("start", 0);
        check("start code7", code[7], 8'h10);
        check("start code0", code[0], 8'h17);
        check("start busy", 8'(busy), 8'h01);
        check("start step", 8'(step), 8'h00);

        // left scroll with wrap
        do_step("s1");
        check("s1 code7", code[7], 8'h11);
        check("s1 code0", code[0], 8'h18);
        for (int i = 2; i <= 9; i++) do_step($sformatf("s%0d", i));
        check_win("s9", 9);
        check("s9 code7", code[7], 8'h19);
        check("s9 code0", code[0], 8'h10);

        // right scroll from pos 0
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check_blank("stop");
        check("stop busy", 8'(busy), 8'h00);
        start = 1'b1; dir = 1'b1;
        cyc();
        start = 1'b0;
        check_win("restart", 0);
        do_step("right");
        check("right code7", code[7], 8'h1F);
        check("right code6", code[6], 8'h10);
        check("right code0", code[0], 8'h16);

        // pause two cycles into the period, resume finishes the remaining two
        cyc();
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("pause busy", 8'(busy), 8'h01);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("paused step", 8'(step), 8'h00);
            check("paused code7", code[7], 8'h1F);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("resume +0 step", 8'(step), 8'h00);
        cyc();
        check("resume +1 step", 8'(step), 8'h00);
        cyc();
        check("resume +2 step", 8'(step), 8'h01);
        check_win("resume", 14);

        // write on the step edge into the incoming leftmost digit
        dir = 1'b0;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'hAA;
        cyc();
        wr_en = 1'b0;
        check("wr step", 8'(step), 8'h01);
        check("wr old code7", code[7], 8'h11);
        check_win("wr old", 1);
        model[1] = 8'hAA;
        for (int i = 0; i < 9; i++) do_step($sformatf("w%0d", i));
        check_win("wr pos10", 10);
        check("wr pos10 code0", code[0], 8'hAA);
        for (int i = 9; i < 16; i++) do_step($sformatf("w%0d", i));
        check("wr new code7", code[7], 8'hAA);
        check_win("wr pos1", 1);

        // start and stop together in RUN
        cyc();
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        check("startstop busy", 8'(busy), 8'h00);
        check("startstop step", 8'(step), 8'h00);
        check_blank("startstop");

        // reset on the edge that would have stepped
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst busy", 8'(busy), 8'h00);
        check_blank("rst");
        for (int i = 0; i < 20; i++) begin
            check("post rst step", 8'(step), 8'h00);
            cyc();
        end

        // message survives reset
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("keep code7", code[7], 8'h10);
        check("keep code6", code[6], 8'hAA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
